// File: rtl/next_pc_if.sv
// next_pc_if: request/redirect bundle between the pipeline control and the next-PC unit.
interface next_pc_if #(parameter int DATA_WIDTH = 32);
   logic                  stall;
   logic                  br_taken;
   logic [DATA_WIDTH-1:0] br_base;
   logic [DATA_WIDTH-1:0] br_offset;
   logic                  jump;
   logic [25:0]           jump_index;
   logic                  jr;
   logic [DATA_WIDTH-1:0] jr_target;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] pc_plus4;
   logic                  flush;
   logic                  addr_exc;
   modport master (
      output stall, br_taken, br_base, br_offset, jump, jump_index, jr, jr_target,
      input  pc, pc_plus4, flush, addr_exc
   );
   modport slave (
      input  stall, br_taken, br_base, br_offset, jump, jump_index, jr, jr_target,
      output pc, pc_plus4, flush, addr_exc
   );
endinterface

// File: rtl/next_pc_unit.sv
// next_pc_unit: fetch PC register with prioritised branch/jump/jr redirects, stall-deferred
// pending target, misaligned-target exception vectoring and one-cycle flush pulse.
module next_pc_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_3000,
   parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = 32'h0000_4180
) (
   input logic      clk,
   input logic      rst_n,
   next_pc_if.slave bus
);
   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] PEND  = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   logic [1:0]            state, state_next;
   logic [DATA_WIDTH-1:0] pc_q, pend_q, br_tgt, jmp_tgt, req_tgt, sel_tgt, redir_tgt;
   logic                  flush_q, exc_q, req, pending, apply, misaligned;
   assign br_tgt     = bus.br_base + bus.br_offset;
   assign jmp_tgt    = {bus.br_base[DATA_WIDTH-1:28], bus.jump_index, 2'b00};
   assign req        = bus.jr | bus.jump | bus.br_taken;
   assign req_tgt    = bus.jr ? bus.jr_target : bus.jump ? jmp_tgt : br_tgt;
   assign pending    = state == PEND;
   // A live request always supersedes a stored one, whether stalled or not.
   assign sel_tgt    = req ? req_tgt : pend_q;
   assign apply      = !bus.stall && (req || pending);
   assign misaligned = sel_tgt[1:0] != 2'b00;
   assign redir_tgt  = misaligned ? EXC_VECTOR : sel_tgt;
   assign state_next = apply ? FLUSH : (bus.stall && (req || pending)) ? PEND : RUN;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         flush_q <= 1'b0;
         exc_q   <= 1'b0;
      end else begin
         state   <= state_next;
         pc_q    <= apply ? redir_tgt : bus.stall ? pc_q : pc_q + DATA_WIDTH'(4);
         pend_q  <= (bus.stall && req) ? req_tgt : pend_q;
         flush_q <= apply;
         exc_q   <= apply && misaligned;
      end
   end
   assign bus.pc       = pc_q;
   assign bus.pc_plus4 = pc_q + DATA_WIDTH'(4);
   assign bus.flush    = flush_q;
   assign bus.addr_exc = exc_q;
endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of all address buses.
REQ-002 Parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_4180: PC loaded on misaligned redirect target.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stall  input  1  hold PC this cycle.
REQ-007 br_taken  input  1  resolved conditional branch taken.
REQ-008 br_base  input  DATA_WIDTH  PC+4 of the resolving branch.
REQ-009 br_offset  input  DATA_WIDTH  sign-extended offset, already shifted left by 2.
REQ-010 jump  input  1  J/JAL request.
REQ-011 jump_index  input  26  instr_index field.
REQ-012 jr  input  1  JR/JALR request.
REQ-013 jr_target  input  DATA_WIDTH  register-sourced target.
REQ-014 pc  output  DATA_WIDTH  current fetch address (registered).
REQ-015 pc_plus4  output  DATA_WIDTH  pc + 4 (combinational from pc).
REQ-016 flush  output  1  registered; high one cycle after a redirect is applied.
REQ-017 addr_exc  output  1  registered; high one cycle when a misaligned target was replaced by EXC_VECTOR.

Function
REQ-018 Branch target SHALL be br_base + br_offset, modulo 2^DATA_WIDTH (wrap, no overflow flag).
REQ-019 Jump target SHALL be {br_base[31:28], jump_index, 2'b00}.
REQ-020 Request priority SHALL be jr > jump > br_taken; only the winner forms the redirect target.
REQ-021 A target with bits [1:0] != 0 SHALL be replaced by EXC_VECTOR, with addr_exc asserted the cycle after it is applied.
REQ-022 FSM states: RUN, PEND, FLUSH.
REQ-023 RUN, no request, stall=0: pc <= pc + 4 (wraps 0xFFFF_FFFC -> 0x0000_0000).
REQ-024 RUN, stall=1, no request: pc holds.
REQ-025 RUN, request, stall=0: pc <= target, flush <= 1, go FLUSH.
REQ-026 RUN, request, stall=1: latch target into pending register, pc holds, go PEND.
REQ-027 PEND, stall=1: pc holds; a new request in this cycle SHALL overwrite the pending target.
REQ-028 PEND, stall=0: pc <= request target if a request is present this cycle, else pending target; flush <= 1, go FLUSH.
REQ-029 FLUSH: flush <= 0; then behave exactly as RUN for this cycle's inputs (stall, request).
REQ-030 Redirect latency SHALL be one cycle: target visible on pc the edge after the accepting cycle.
REQ-031 flush and addr_exc SHALL never be high for two consecutive cycles unless two redirects are applied back-to-back.

Reset
REQ-032 rst_n=0 SHALL immediately force pc=RESET_PC, flush=0, addr_exc=0, pending register=0, state=RUN, regardless of clk.
REQ-033 Reset asserted mid-PEND SHALL discard the pending target; first post-reset edge with stall=0 gives pc=RESET_PC+4.
REQ-034 Release of rst_n SHALL not itself cause a redirect or flush.

Verification
REQ-035 Reset, then 3 edges stall=0, no requests -> pc 0x3000, 0x3004, 0x3008, 0x300C; flush=0 throughout.
REQ-036 pc=0x3010, br_taken=1, br_base=0x3014, br_offset=0xFFFF_FFF0 -> next pc=0x3004, flush=1 for one cycle.
REQ-037 jr=1 jr_target=0x5000 with jump=1 and br_taken=1 in same cycle -> pc=0x5000 (jr wins).
REQ-038 jump=1 with stall=1 for 3 cycles, jump_index=0x000_0100, br_base=0x0000_3004 -> pc holds 3 cycles, then pc=0x0000_0400, flush=1.
REQ-039 jr_target=0x0000_5002 -> pc=0x0000_4180, addr_exc=1 and flush=1 for one cycle.
REQ-040 rst_n pulsed low between clock edges while in PEND -> pc=0x3000 immediately, pending discarded, next unstalled edge pc=0x3004.
